// File: rtl/hex_disp_ctrl_if.sv
// Avalon-MM slave bus bundle for the front-panel hex display controller.
// The CPU side drives the master modport; the display controller uses the slave modport.
interface hex_disp_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/hex_disp_ctrl.sv
// Six-digit 7-segment display controller for the vending-machine front panel.
// The CPU writes a packed 24-bit nibble value. That value is committed to the display
// on a refresh tick, or immediately when forced, so all six digits change together
// and never show a mix of old and new digits. Control bits select enable,
// leading-zero blanking and a per-digit blink mask. Segment outputs are active-low
// and registered.
module hex_disp_ctrl #(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic            clk,
    input  logic            reset_n,
    hex_disp_ctrl_if.slave  bus,
    output logic [6:0]      hex0,
    output logic [6:0]      hex1,
    output logic [6:0]      hex2,
    output logic [6:0]      hex3,
    output logic [6:0]      hex4,
    output logic [6:0]      hex5
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    tick_cnt_q;
    logic [BCNT_W-1:0]   blink_cnt_q;
    logic                phase_q;
    logic [23:0]         pending_q;
    logic [23:0]         active_q;
    logic                en_q;
    logic                lzb_q;
    logic [5:0]          blink_q;
    logic [5:0][6:0]     hex_q;
    logic [5:0][6:0]     hex_d;

    logic tick;
    logic wr;
    logic wr_data;
    logic wr_ctrl;
    logic force_apply;
    logic unused_wd;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign wr_data     = wr && (bus.address == 2'd0);
    assign wr_ctrl     = wr && (bus.address == 2'd1);
    assign force_apply = wr && (bus.address == 2'd2) && bus.writedata[0];
    assign tick        = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign unused_wd   = &{1'b0, bus.writedata[31:24]};

    // Active-low segment code for one hex nibble (bit0 = a ... bit6 = g).
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Free-running refresh tick divider: one-cycle tick at the end of each period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Blink phase: toggles every BLINK_TICKS ticks, starts in the "on" phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BCNT_W'(BLINK_TICKS - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // Commit FSM: holds the latest written value until a tick or force, then copies it in one step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            active_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_data) begin
                        pending_q <= bus.writedata[23:0];
                        state_q   <= S_PEND;
                    end
                end
                S_PEND: begin
                    // A write in the same cycle as the tick still gets committed,
                    // since APPLY reads pending one cycle later.
                    if (wr_data) begin
                        pending_q <= bus.writedata[23:0];
                    end
                    if (tick || force_apply) begin
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    active_q <= pending_q;
                    if (wr_data) begin
                        pending_q <= bus.writedata[23:0];
                        state_q   <= S_PEND;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Control register: takes effect immediately, not tied to the refresh tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            lzb_q   <= 1'b0;
            blink_q <= '0;
        end else if (wr_ctrl) begin
            en_q    <= bus.writedata[0];
            lzb_q   <= bus.writedata[1];
            blink_q <= bus.writedata[13:8];
        end
    end

    // Per-digit decode with leading-zero and blink blanking, scanning from the top digit down.
    always_comb begin
        logic       all_zero;
        logic [3:0] nib;
        logic       blank;
        hex_d    = '0;
        all_zero = 1'b1;
        nib      = '0;
        blank    = 1'b0;
        for (int k = 5; k >= 0; k--) begin
            nib      = active_q[4*k +: 4];
            all_zero = all_zero & (nib == 4'h0);
            blank    = (lzb_q && all_zero && (k != 0)) || (blink_q[k] && phase_q);
            hex_d[k] = (!en_q || blank) ? 7'h7F : seg7(nib);
        end
    end

    // Registered segment outputs; blank during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q <= {6{7'h7F}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

    // Combinational register read mux, zero-extended.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata = {8'd0, pending_q};
            2'd1: bus.readdata = {18'd0, blink_q, 6'd0, lzb_q, en_q};
            2'd2: bus.readdata = {30'd0, phase_q, (state_q == S_PEND)};
            default: bus.readdata = {8'd0, active_q};
        endcase
    end

endmodule

// File: doc/hex_disp_ctrl.md
Name: hex_disp_ctrl

Overview:
- Avalon-MM slave display controller that owns all six 7-segment digits (hex0..hex5) on the vending-machine front panel.
- The CPU writes a 24-bit packed-nibble value plus control bits. The block handles:
  - tick-synchronised, tear-free commit of new values;
  - per-digit blink;
  - leading-zero blanking;
  - hex-to-segment decoding.
- It replaces per-digit software segment encoding.

Parameters:
- TICK_DIV, 50000, clk cycles per refresh tick (1 kHz at 50 MHz); minimum 2.
- BLINK_TICKS, 250, ticks per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read mux, zero-extended
- hex0..hex5  out  7 each  segment drive; active-low; bit0=a … bit6=g; hexk shows nibble k

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous and active-low.
  - Reset clears pending, active, ctrl, both counters, phase and state.
  - All hex outputs reset to 7'h7F (blank); readdata then reads 0.
- Write strobe: a write occurs when chipselect=1, write_n=0, and is captured on the clock edge.
- Register 0, DATA:
  - Write: pending <= writedata[23:0]; state -> PEND.
  - Read: pending.
- Register 1, CTRL:
  - Fields: bit0 EN; bit1 LZB; bits[13:8] BLINK mask (bit8 = hex0).
  - Write takes effect the next cycle; it is not tick-synchronised.
  - Read: CTRL with unused bits 0.
- Register 2, STATUS:
  - Read: bit0 = (state==PEND); bit1 = blink phase.
  - Write with writedata[0]=1 while in PEND forces APPLY on the next cycle, without waiting for a tick.
  - Other writes are ignored.
- Register 3, ACTIVE:
  - Read: the 24-bit value currently displayed.
  - Writes are ignored.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when count == TICK_DIV-1.
- Blink counter:
  - Counts ticks 0..BLINK_TICKS-1.
  - phase toggles on the wrap tick; phase=0 (on) after reset.
- Commit FSM (states IDLE, PEND, APPLY):
  - IDLE: a DATA write -> PEND.
  - PEND: on tick, or on force via STATUS -> APPLY.
  - APPLY (one cycle): active <= pending.
    - Next state is PEND if a DATA write occurs in this same cycle (the new pending waits for the next tick), else IDLE.
  - A DATA write while in PEND overwrites pending and stays in PEND; only the last value is committed.
- Digit decode, per digit k, from active, ctrl and phase:
  - EN=0: all digits 7F.
  - blank_k = LZB-blank OR (BLINK[k] AND phase=1).
  - LZB blanking: digit k (k=5..1) is blanked when nibble k and all higher nibbles are 0. hex0 is never LZB-blanked.
  - Blanked digit = 7F.
  - Otherwise active-low codes, digits 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Output timing:
  - hex outputs are registered: 1-cycle latency from any change of active, ctrl or phase.
  - DATA write to visible: worst case TICK_DIV+2 cycles.
- Mid-operation reset: reset asserted in PEND or APPLY discards pending; outputs go blank immediately (asynchronous).

Test Plan:
- Bench parameters: TICK_DIV=4, BLINK_TICKS=2.
- Reset release -> all hex = 7F; reads of registers 0..3 return 0.
- CTRL=1, DATA=0x123456 -> STATUS bit0=1 until the next tick; one cycle after APPLY, hex5..hex0 = 79,24,30,19,12,02 and ACTIVE reads 0x123456.
- DATA=0x000000 then DATA=0x00ABCD before the tick -> only 0x00ABCD is committed. With CTRL=3 (LZB on): hex5=hex4=7F, hex3..hex0 = 08,03,46,21. With DATA=0 and LZB on: hex0=40, others 7F.
- CTRL=0x0101 (blink hex0), value 0x000008 -> hex0 alternates 00 / 7F every 8 cycles (2 ticks × 4); other digits stay 40; STATUS bit1 tracks phase.
- DATA=0x111111 then STATUS write 1 -> APPLY the next cycle, before any tick. A DATA write in the APPLY cycle -> state returns to PEND with the new value pending.
- reset_n pulled low while in PEND -> outputs 7F in the same cycle; after release, ACTIVE=0, STATUS=0, and nothing is committed.
